// File: rtl/thdi_frame_if.sv
// Bundle of ADC strobe, frame buffer, engine handshake and status signals
// for the THDi frame sequencer.
interface thdi_frame_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 5
);
    logic                     enable;
    logic                     sample_valid;
    logic signed [DATA_W-1:0] d_in;
    logic signed [DATA_W-1:0] d_out;
    logic                     sipo_shift;
    logic [IDX_W-1:0]         frame_idx;
    logic                     sipo_arm_n;
    logic                     calc_start;
    logic                     calc_done;
    logic                     frame_valid;
    logic                     overrun;
    logic                     timeout;
    logic                     clear_flags;
    logic [15:0]              frame_count;

    // Sequencer side
    modport master (
        input  enable, sample_valid, d_in, calc_done, clear_flags,
        output d_out, sipo_shift, frame_idx, sipo_arm_n, calc_start,
               frame_valid, overrun, timeout, frame_count
    );

    // ADC / buffer / engine / host side
    modport slave (
        output enable, sample_valid, d_in, calc_done, clear_flags,
        input  d_out, sipo_shift, frame_idx, sipo_arm_n, calc_start,
               frame_valid, overrun, timeout, frame_count
    );
endinterface

// File: rtl/thdi_frame_ctrl.sv
// THDi frame sequencer: gathers FRAME_LEN samples into the SIPO frame
// buffer, starts the harmonic engine once, holds the frame until the engine
// finishes (or times out) and re-arms while enable stays high.
module thdi_frame_ctrl #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 32,
    parameter int TIMEOUT   = 4096,
    parameter int IDX_W     = $clog2(FRAME_LEN)
) (
    input logic         clk,
    input logic         rst,
    thdi_frame_if.master bus
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_COLLECT = 3'd2;
    localparam logic [2:0] S_START   = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;

    logic [2:0]               state;
    logic [2:0]               state_nx;
    logic [IDX_W-1:0]         cnt;
    logic [TO_W-1:0]          tcnt;
    logic signed [DATA_W-1:0] d_p1;
    logic [IDX_W-1:0]         idx_p1;
    logic                     vld_p1;
    logic                     overrun_q;
    logic                     timeout_q;
    logic [15:0]              frame_count_q;

    logic accept;
    logic overrun_set;
    logic timeout_set;
    logic done_ok;

    // A sample is taken only while collecting with acquisition still enabled;
    // an abort cycle drops the sample together with the partial frame.
    assign accept      = (state == S_COLLECT) && bus.enable && bus.sample_valid;
    assign overrun_set = bus.sample_valid &&
                         ((state == S_ARM) || (state == S_START) || (state == S_WAIT));
    assign done_ok     = (state == S_WAIT) && bus.calc_done;
    assign timeout_set = (state == S_WAIT) && !bus.calc_done && (tcnt == TO_LAST);

    // Next-state selection; completion takes priority over the timeout limit
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (bus.enable) state_nx = S_ARM;
            S_ARM:     state_nx = bus.enable ? S_COLLECT : S_IDLE;
            S_COLLECT: begin
                if (!bus.enable)
                    state_nx = S_IDLE;
                else if (bus.sample_valid && (cnt == IDX_LAST))
                    state_nx = S_START;
            end
            S_START:   state_nx = S_WAIT;
            S_WAIT: begin
                if (bus.calc_done)
                    state_nx = bus.enable ? S_ARM : S_IDLE;
                else if (tcnt == TO_LAST)
                    state_nx = S_IDLE;
            end
            default:   state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Sample counter and one-cycle registered write to the frame buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            d_p1   <= '0;
            idx_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept;
            if (state == S_ARM)
                cnt <= '0;
            else if (accept)
                cnt <= cnt + 1'b1;
            if (accept) begin
                d_p1   <= bus.d_in;
                idx_p1 <= cnt;
            end
        end
    end

    // Engine watchdog: cleared while starting, advances each WAIT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tcnt <= '0;
        else if (state == S_START)
            tcnt <= '0;
        else if (state == S_WAIT)
            tcnt <= tcnt + 1'b1;
    end

    // Sticky flags (a set beats a same-cycle clear) and completed-frame count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            if (overrun_set)
                overrun_q <= 1'b1;
            else if (bus.clear_flags)
                overrun_q <= 1'b0;
            if (timeout_set)
                timeout_q <= 1'b1;
            else if (bus.clear_flags)
                timeout_q <= 1'b0;
            if (done_ok)
                frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign bus.d_out       = d_p1;
    assign bus.sipo_shift  = vld_p1;
    assign bus.frame_idx   = idx_p1;
    assign bus.sipo_arm_n  = (state != S_ARM);
    assign bus.calc_start  = (state == S_START);
    assign bus.frame_valid = (state == S_START) || (state == S_WAIT);
    assign bus.overrun     = overrun_q;
    assign bus.timeout     = timeout_q;
    assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_thdi_frame_ctrl.sv
// Directed bench for thdi_frame_ctrl with a scoreboard of expected buffer
// writes (index, data) that is drained as sipo_shift pulses appear.
module tb_thdi_frame_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    thdi_frame_if #(.DATA_W(16), .IDX_W(5)) bus ();

    thdi_frame_ctrl #(
        .DATA_W(16),
        .FRAME_LEN(32),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [4:0]  idx;
        logic [15:0] data;
    } exp_t;

    exp_t sbq[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   arm_cnt   = 0;
    int   start_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (bus.sipo_arm_n === 1'b0) arm_cnt++;
        if (bus.calc_start === 1'b1) start_cnt++;
        if (bus.sipo_shift !== 1'b0) begin
            if (sbq.size() == 0) begin
                check("unexpected_shift", 32'(bus.sipo_shift), 32'd0);
            end else begin
                e = sbq.pop_front();
                check("frame_idx", 32'(bus.frame_idx), 32'(e.idx));
                check("d_out", 32'($unsigned(bus.d_out)), 32'(e.data));
            end
        end
    endtask

    // Drive n back-to-back samples base, base+1, ... expecting indices 0..n-1
    task automatic send(input int n, input int base);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            bus.sample_valid = 1'b1;
            bus.d_in         = 16'(base + i);
            e.idx            = 5'(i);
            e.data           = 16'(base + i);
            sbq.push_back(e);
            tick();
        end
        bus.sample_valid = 1'b0;
    endtask

    task automatic check_reset();
        check("rst_d_out",       32'($unsigned(bus.d_out)), 32'd0);
        check("rst_sipo_shift",  32'(bus.sipo_shift),  32'd0);
        check("rst_frame_idx",   32'(bus.frame_idx),   32'd0);
        check("rst_sipo_arm_n",  32'(bus.sipo_arm_n),  32'd1);
        check("rst_calc_start",  32'(bus.calc_start),  32'd0);
        check("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
        check("rst_overrun",     32'(bus.overrun),     32'd0);
        check("rst_timeout",     32'(bus.timeout),     32'd0);
        check("rst_frame_count", 32'(bus.frame_count), 32'd0);
    endtask

    initial begin
        bus.enable       = 1'b0;
        bus.sample_valid = 1'b0;
        bus.d_in         = '0;
        bus.calc_done    = 1'b0;
        bus.clear_flags  = 1'b0;

        // Reset state
        #12;
        check_reset();
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Full frame 0..31
        bus.enable = 1'b1;
        tick();
        check("arm_low", 32'(bus.sipo_arm_n), 32'd0);
        tick();
        check("arm_one_cycle", 32'(bus.sipo_arm_n), 32'd1);
        send(32, 0);
        check("f1_calc_start", 32'(bus.calc_start), 32'd1);
        check("f1_frame_valid", 32'(bus.frame_valid), 32'd1);
        check("f1_sb_empty", 32'(sbq.size()), 32'd0);
        check("f1_arm_pulses", 32'(arm_cnt), 32'd1);
        tick();
        check("f1_start_once", 32'(bus.calc_start), 32'd0);
        check("f1_fv_hold", 32'(bus.frame_valid), 32'd1);

        // Samples throughout WAIT; last one coincides with clear_flags
        for (int i = 1; i <= 9; i++) begin
            bus.sample_valid = 1'b1;
            bus.d_in         = 16'(16'h7000 + i);
            bus.clear_flags  = (i == 9);
            tick();
        end
        bus.sample_valid = 1'b0;
        bus.clear_flags  = 1'b0;
        check("ovr_set_wins", 32'(bus.overrun), 32'd1);
        check("ovr_fv_hold", 32'(bus.frame_valid), 32'd1);
        check("ovr_data_intact", 32'($unsigned(bus.d_out)), 32'd31);
        check("ovr_idx_intact", 32'(bus.frame_idx), 32'd31);
        check("f1_start_count", 32'(start_cnt), 32'd1);

        // calc_done 10 cycles after calc_start
        bus.calc_done = 1'b1;
        tick();
        bus.calc_done = 1'b0;
        check("done_fv_fall", 32'(bus.frame_valid), 32'd0);
        check("done_count", 32'(bus.frame_count), 32'd1);
        check("done_rearm", 32'(bus.sipo_arm_n), 32'd0);
        bus.clear_flags = 1'b1;
        tick();
        bus.clear_flags = 1'b0;
        check("ovr_cleared", 32'(bus.overrun), 32'd0);

        // Abort after 17 accepted samples
        send(17, -1000);
        check("abort_sb_empty", 32'(sbq.size()), 32'd0);
        bus.enable = 1'b0;
        tick();
        check("abort_fv", 32'(bus.frame_valid), 32'd0);
        check("abort_arm_n", 32'(bus.sipo_arm_n), 32'd1);
        check("abort_no_start", 32'(bus.calc_start), 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.sample_valid = 1'b1;
            bus.calc_done    = 1'b1;
            tick();
        end
        bus.sample_valid = 1'b0;
        bus.calc_done    = 1'b0;
        check("idle_no_overrun", 32'(bus.overrun), 32'd0);
        check("idle_done_ignored", 32'(bus.frame_count), 32'd1);
        check("abort_start_count", 32'(start_cnt), 32'd1);

        // Engine timeout (TIMEOUT=16)
        bus.enable = 1'b1;
        tick();
        check("to_arm", 32'(bus.sipo_arm_n), 32'd0);
        tick();
        send(32, 100);
        check("to_calc_start", 32'(bus.calc_start), 32'd1);
        check("to_sb_empty", 32'(sbq.size()), 32'd0);
        for (int i = 0; i < 16; i++) tick();
        check("to_not_yet", 32'(bus.timeout), 32'd0);
        check("to_fv_before", 32'(bus.frame_valid), 32'd1);
        bus.enable = 1'b0;
        tick();
        check("to_flag", 32'(bus.timeout), 32'd1);
        check("to_fv_clear", 32'(bus.frame_valid), 32'd0);
        check("to_count_same", 32'(bus.frame_count), 32'd1);
        check("to_idle", 32'(bus.sipo_arm_n), 32'd1);
        tick();
        check("to_stay_idle", 32'(bus.sipo_arm_n), 32'd1);
        bus.clear_flags = 1'b1;
        tick();
        bus.clear_flags = 1'b0;
        check("to_cleared", 32'(bus.timeout), 32'd0);

        // Reset mid-COLLECT after 20 samples
        bus.enable = 1'b1;
        tick();
        tick();
        send(20, 16'h1234);
        #1;
        rst = 1'b1;
        #1;
        check_reset();
        check("rst_sb_empty", 32'(sbq.size()), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_arm", 32'(bus.sipo_arm_n), 32'd0);
        tick();
        send(32, -50);
        check("post_rst_start", 32'(bus.calc_start), 32'd1);
        check("post_rst_fv", 32'(bus.frame_valid), 32'd1);
        check("post_rst_sb_empty", 32'(sbq.size()), 32'd0);
        bus.enable = 1'b0;
        tick();
        bus.calc_done = 1'b1;
        tick();
        bus.calc_done = 1'b0;
        check("post_rst_count", 32'(bus.frame_count), 32'd1);
        check("post_rst_fv_fall", 32'(bus.frame_valid), 32'd0);
        check("post_rst_idle", 32'(bus.sipo_arm_n), 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/thdi_frame_ctrl.md
# thdi_frame_ctrl

Frame sequencer for the THDi computation path. Collects 32 signed 16-bit current samples from the ADC strobe interface into the serial-in/parallel-out frame buffer. Then issues a single start pulse to the harmonic computation engine and holds the frame stable until the engine reports completion. Flags overruns and engine timeouts, and re-arms automatically while acquisition is enabled.

## Interface
- FRAME_LEN, 32: samples per frame. IDX_W = clog2(FRAME_LEN).
- TIMEOUT, 4096: maximum cycles to wait for calc_done after calc_start.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  acquisition enable (level).
- sample_valid  in  1  one-cycle strobe; d_in valid this cycle.
- d_in  in  16  signed sample.
- d_out  out  16  registered sample to frame buffer; reset 0.
- sipo_shift  out  1  one-cycle write qualifier for d_out; reset 0.
- frame_idx  out  IDX_W  index of the sample carried by d_out; reset 0.
- sipo_arm_n  out  1  active-low buffer arm pulse; reset 1.
- calc_start  out  1  one-cycle engine start; reset 0.
- calc_done  in  1  one-cycle engine completion.
- frame_valid  out  1  buffer contents stable for engine; reset 0.
- overrun  out  1  sticky: sample arrived when it could not be accepted; reset 0.
- timeout  out  1  sticky: engine exceeded TIMEOUT; reset 0.
- clear_flags  in  1  clears overrun and timeout.
- frame_count  out  16  completed frames, wraps at 65535->0; reset 0.

## Operation
- States: IDLE, ARM, COLLECT, START, WAIT. Reset state is IDLE.
- IDLE: all strobes are low. If enable=1, go to ARM. sample_valid is ignored and does not set overrun.
- ARM: lasts one cycle, with sipo_arm_n=0. The sample counter clears. Next state is COLLECT.
- COLLECT: each sample_valid produces, on the next cycle:
  - d_out=d_in and sipo_shift=1;
  - frame_idx set to the current count;
  - the count increments.
- COLLECT exit: on acceptance of sample FRAME_LEN-1, go to START.
- START: lasts one cycle, with calc_start=1 and frame_valid set to 1. Next state is WAIT, and the timeout counter clears.
- WAIT:
  - frame_valid is held at 1.
  - On calc_done: frame_count increments and frame_valid clears. Go to ARM if enable=1, otherwise IDLE.
  - If the counter reaches TIMEOUT without calc_done: set timeout, clear frame_valid, go to IDLE. frame_count is unchanged.
- Overrun: sample_valid in ARM, START or WAIT sets overrun. The sample is dropped and no sipo_shift is issued.
- enable=0 in ARM or COLLECT: abort to IDLE next cycle. The partial frame is discarded, and no calc_start is issued.
- enable=0 in START or WAIT: does not abort. The engine finishes, then the block goes to IDLE.
- calc_done outside WAIT: ignored.
- clear_flags together with a flag-setting event in the same cycle: the set wins.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous). The state becomes IDLE, and the counters and flags clear.

## Timing
- enable rises in cycle 0:
  - ARM in cycle 1 (sipo_arm_n=0);
  - COLLECT from cycle 2;
  - first sample accepted on a sample_valid in cycle 2 or later.
- Sample to buffer latency: 1 cycle (sample_valid at n gives sipo_shift and d_out at n+1).
- Back-to-back sample_valid is allowed. The minimum frame duration is 32 cycles of COLLECT.
- Last sample accepted at cycle n:
  - sipo_shift for index 31 at n+1;
  - calc_start at n+1;
  - frame_valid rises at n+1.
- calc_done at cycle m: frame_valid falls at m+1, frame_count updates at m+1, ARM at m+1.
- Timeout: fires after TIMEOUT cycles in WAIT. timeout rises the cycle after the limit is reached.

## Test plan
- Reset then enable=1, 32 consecutive sample_valid with d_in=0..31:
  - sipo_arm_n low exactly 1 cycle;
  - 32 sipo_shift pulses with frame_idx 0..31 and d_out matching;
  - calc_start exactly once;
  - frame_valid=1.
- Same frame, then calc_done 10 cycles after calc_start: frame_valid falls the next cycle, frame_count=1, sipo_arm_n pulses again.
- Drive sample_valid every cycle through WAIT:
  - overrun=1, no sipo_shift while in WAIT, frame data intact;
  - clear_flags then clears overrun.
- enable=0 after 17 accepted samples: IDLE next cycle, no calc_start, frame_count unchanged.
- Withhold calc_done with TIMEOUT=16: timeout=1 after 16 WAIT cycles, frame_valid=0, IDLE, frame_count unchanged.
- Assert rst mid-COLLECT at sample 20: all outputs immediately return to reset values. After release with enable=1, a full new frame starts at frame_idx 0.
